// File: rtl/key_report_uart_tx.sv
// Formats a captured (priv_key, pub_x) pair as a 130-char ASCII hex line
// and streams it out as back-to-back 8N1 UART characters.
module key_report_uart_tx #(
   parameter int unsigned BAUD_DIV = 104,
   parameter logic [7:0]  SEP_CHAR = 8'h3A,
   parameter logic [7:0]  EOL_CHAR = 8'h0A
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [255:0] priv_key,
   input  logic [255:0] pub_x,
   input  logic         abort,
   output logic         busy,
   output logic         done,
   output logic [7:0]   char_idx,
   output logic         uart_tx
);

   localparam int BW = $clog2(BAUD_DIV);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t         r_state;
   logic [255:0]   r_priv;
   logic [255:0]   r_pub;
   logic [BW-1:0]  r_baud;
   logic [2:0]     r_bit;
   logic [7:0]     r_char;
   logic           r_abort;
   logic           r_tx;
   logic           r_busy;
   logic           r_rdy;
   logic           r_done;

   logic           w_last_baud;
   logic           w_abort;
   logic [2:0]     w_nbit;
   logic [5:0]     w_pidx;
   logic [3:0]     w_nib;
   logic [7:0]     w_hex;
   logic [7:0]     w_byte;

   assign w_last_baud = (r_baud == BW'(BAUD_DIV - 1));
   assign w_abort     = r_abort | abort;
   assign w_nbit      = r_bit + 3'd1;
   assign w_pidx      = 6'(r_char - 8'd65);

   // Most significant nibble first for both words
   always_comb begin
      w_nib = 4'h0;
      if (r_char < 8'd64)
         w_nib = r_priv[8'd252 - {r_char[5:0], 2'b00} +: 4];
      else
         w_nib = r_pub[8'd252 - {w_pidx, 2'b00} +: 4];
      w_hex = (w_nib < 4'd10) ? 8'h30 + {4'h0, w_nib}
                              : 8'h37 + {4'h0, w_nib};
      w_byte = w_hex;
      if (r_char == 8'd64)
         w_byte = SEP_CHAR;
      else if (r_char == 8'd129)
         w_byte = EOL_CHAR;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_priv  <= '0;
         r_pub   <= '0;
         r_baud  <= '0;
         r_bit   <= '0;
         r_char  <= '0;
         r_abort <= 1'b0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_rdy   <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_busy && abort)
            r_abort <= 1'b1;
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_priv  <= priv_key;
                  r_pub   <= pub_x;
                  r_baud  <= '0;
                  r_char  <= '0;
                  r_abort <= 1'b0;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_rdy   <= 1'b0;
                  r_state <= START;
               end
            end
            START: begin
               if (w_last_baud) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_tx    <= w_byte[0];
                  r_state <= DATA;
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            DATA: begin
               if (w_last_baud) begin
                  r_baud <= '0;
                  if (r_bit == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_bit <= w_nbit;
                     r_tx  <= w_byte[w_nbit];
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            STOP: begin
               if (w_last_baud) begin
                  r_baud <= '0;
                  if (r_char < 8'd129 && !w_abort) begin
                     r_char  <= r_char + 8'd1;
                     r_tx    <= 1'b0;
                     r_state <= START;
                  end else begin
                     // An aborted line ends silently, without done
                     r_char  <= '0;
                     r_busy  <= 1'b0;
                     r_rdy   <= 1'b1;
                     r_done  <= ~w_abort;
                     r_state <= IDLE;
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
         endcase
      end
   end

   assign in_ready = r_rdy;
   assign busy     = r_busy;
   assign done     = r_done;
   assign char_idx = r_char;
   assign uart_tx  = r_tx;

endmodule

// File: tb/tb_key_report_uart_tx.sv
// Bench for key_report_uart_tx: UART decoder feeding a character scoreboard,
// a character table for the fixed line, and timing/corner sequences.
module tb_key_report_uart_tx;

   localparam int B    = 4;
   localparam int LINE = 1300 * B;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         abort = 1'b0;
   logic [255:0] priv_key = '0;
   logic [255:0] pub_x = '0;
   logic         in_ready;
   logic         busy;
   logic         done;
   logic [7:0]   char_idx;
   logic         uart_tx;

   always #5 clk = ~clk;

   key_report_uart_tx #(.BAUD_DIV(B)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .priv_key (priv_key),
      .pub_x    (pub_x),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .char_idx (char_idx),
      .uart_tx  (uart_tx)
   );

   int          n_checks = 0;
   int          n_fail = 0;
   longint      cyc = 0;
   int          done_cnt = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  rx_line [0:255];
   int          rx_n = 0;
   longint      t_start;

   typedef struct {
      int         idx;
      logic [7:0] ch;
   } vec_t;
   vec_t tv [14];

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] hexc(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + 8'(n);
      return 8'h41 + 8'(n) - 8'd10;
   endfunction

   function automatic logic [7:0] lc(input logic [255:0] p,
                                     input logic [255:0] x, input int i);
      logic [255:0] t;
      if (i < 64) begin
         t = p >> (252 - 4 * i);
         return hexc(t[3:0]);
      end
      if (i == 64) return 8'h3A;
      if (i < 129) begin
         t = x >> (252 - 4 * (i - 65));
         return hexc(t[3:0]);
      end
      return 8'h0A;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
      return r;
   endfunction

   // UART decoder: mid-bit sampling, compares each byte to the scoreboard
   bit         m_busy = 0;
   bit         m_frm = 0;
   int         m_cnt = 0;
   logic [7:0] m_byte = '0;
   logic [7:0] m_exp;
   always @(negedge clk) begin
      if (rst) begin
         m_busy = 0;
         m_cnt  = 0;
      end else begin
         if (!m_busy && uart_tx === 1'b0) begin
            m_busy = 1;
            m_cnt  = 0;
         end
         if (m_busy) begin
            if (m_cnt % B == B / 2) begin
               int k;
               k = m_cnt / B;
               if (k == 0) m_frm = (uart_tx === 1'b0);
               else if (k <= 8) m_byte[k-1] = uart_tx;
               else begin
                  m_frm = m_frm && (uart_tx === 1'b1);
                  if (rx_n < 256) rx_line[rx_n] = m_byte;
                  rx_n++;
                  if (exp_q.size() == 0) begin
                     chk("unexpected_char", {55'd0, m_frm, m_byte}, 64'hFFFF);
                  end else begin
                     m_exp = exp_q.pop_front();
                     chk("rx_char", {55'd0, m_frm, m_byte}, {55'd0, 1'b1, m_exp});
                  end
               end
            end
            m_cnt++;
            if (m_cnt == 10 * B) m_busy = 0;
         end
      end
   end

   task automatic capture(input logic [255:0] p, input logic [255:0] x,
                          input int npush, input bit ab);
      int n = 0;
      while (in_ready !== 1'b1 && n < 2 * LINE) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", in_ready, 1);
      for (int i = 0; i < npush; i++) exp_q.push_back(lc(p, x, i));
      rx_n = 0;
      in_valid = 1'b1;
      abort    = ab;
      priv_key = p;
      pub_x    = x;
      @(negedge clk);
      in_valid = 1'b0;
      abort    = 1'b0;
      t_start  = cyc;
   endtask

   task automatic wait_done(input int lim, input string nm);
      int n = 0;
      while (done !== 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(nm, done, 1);
   endtask

   task automatic wait_idx(input logic [7:0] v);
      int n = 0;
      while (char_idx !== v && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("idx_wait", char_idx, v);
   endtask

   function automatic logic wave(input int i);
      logic [7:0] c;
      int k;
      c = 8'h30;
      k = i / B;
      if (k == 0 || k == 10) return 1'b0;
      if (k == 9 || k == 19) return 1'b1;
      if (k < 9) return c[k-1];
      return c[k-11];
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] p, x;
      longint t1, t2;
      int bad, dc0;

      tv[0]  = '{0,   8'h30};
      tv[1]  = '{45,  8'h30};
      tv[2]  = '{46,  8'h38};
      tv[3]  = '{47,  8'h30};
      tv[4]  = '{63,  8'h30};
      tv[5]  = '{64,  8'h3A};
      tv[6]  = '{65,  8'h30};
      tv[7]  = '{66,  8'h31};
      tv[8]  = '{74,  8'h39};
      tv[9]  = '{75,  8'h41};
      tv[10] = '{80,  8'h46};
      tv[11] = '{81,  8'h30};
      tv[12] = '{128, 8'h46};
      tv[13] = '{129, 8'h0A};

      // reset state
      @(negedge clk);
      chk("rst_tx", uart_tx, 1);
      chk("rst_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_idx", char_idx, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // fixed line, bit-level waveform of the first two chars, table
      p = 256'h1 << 71;
      x = {4{64'h0123456789ABCDEF}};
      capture(p, x, 130, 1'b0);
      chk("cap_busy", busy, 1);
      chk("cap_ready", in_ready, 0);
      chk("cap_idx", char_idx, 0);
      for (int i = 0; i < 20 * B; i++) begin
         chk($sformatf("wave_%0d", i), uart_tx, wave(i));
         @(negedge clk);
      end
      wait_done(LINE, "l1_done");
      chk("l1_len", cyc - t_start, LINE);
      chk("l1_busy", busy, 0);
      chk("l1_ready", in_ready, 1);
      chk("l1_idx", char_idx, 0);
      @(negedge clk);
      chk("l1_pulse", done, 0);
      chk("l1_q", exp_q.size(), 0);
      chk("l1_rxn", rx_n, 130);
      for (int i = 0; i < 14; i++)
         chk($sformatf("tbl_%0d", tv[i].idx), rx_line[tv[i].idx], tv[i].ch);

      // abort in idle is ignored; abort coinciding with capture is dropped;
      // in_valid during a line is ignored
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("idle_ab_busy", busy, 0);
      chk("idle_ab_ready", in_ready, 1);
      p = rnd256();
      x = rnd256();
      capture(p, x, 130, 1'b1);
      repeat (1000) @(negedge clk);
      bad = 0;
      in_valid = 1'b1;
      priv_key = '1;
      pub_x    = ~x;
      repeat (100) begin
         if (in_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      for (int n = 0; n < LINE && done !== 1'b1; n++) begin
         if (in_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      chk("busy_ready_low", bad, 0);
      wait_done(10, "l2_done");
      chk("l2_len", cyc - t_start, LINE);
      chk("l2_q", exp_q.size(), 0);

      // asynchronous reset mid data bit of char 10
      @(negedge clk);
      capture('0, rnd256(), 130, 1'b0);
      wait_idx(8'd10);
      repeat (10) @(negedge clk);
      chk("pre_rst_tx", uart_tx, 0);
      chk("pre_rst_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_tx", uart_tx, 1);
      chk("async_busy", busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_idx", char_idx, 0);
      chk("post_rst_done", done, 0);
      chk("post_rst_rxn", rx_n, 10);
      exp_q.delete();

      // in_valid held high: capture in the done cycle, back-to-back lines
      p = rnd256();
      x = rnd256();
      for (int i = 0; i < 260; i++) exp_q.push_back(lc(p, x, i % 130));
      rx_n = 0;
      in_valid = 1'b1;
      priv_key = p;
      pub_x    = x;
      @(negedge clk);
      t_start = cyc;
      chk("b2b_idx", char_idx, 0);
      chk("b2b_busy", busy, 1);
      chk("b2b_tx", uart_tx, 0);
      wait_done(LINE + 10, "b2b_done1");
      t1 = cyc;
      chk("b2b_len", t1 - t_start, LINE);
      chk("b2b_ready", in_ready, 1);
      @(negedge clk);
      chk("b2b_restart_busy", busy, 1);
      chk("b2b_restart_tx", uart_tx, 0);
      chk("b2b_restart_ready", in_ready, 0);
      wait_done(LINE + 10, "b2b_done2");
      t2 = cyc;
      in_valid = 1'b0;
      chk("b2b_gap", t2 - t1, LINE + 1);
      @(negedge clk);
      chk("b2b_end_busy", busy, 0);
      chk("b2b_end_ready", in_ready, 1);
      chk("b2b_q", exp_q.size(), 0);

      // abort during char 5 data bits
      @(negedge clk);
      capture(rnd256(), rnd256(), 6, 1'b0);
      dc0 = done_cnt;
      wait_idx(8'd5);
      repeat (14) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      for (int n = 0; n < 400 && busy !== 1'b0; n++) @(negedge clk);
      chk("ab_len", cyc - t_start, 6 * 10 * B);
      chk("ab_ready", in_ready, 1);
      chk("ab_idx", char_idx, 0);
      bad = 0;
      repeat (60) begin
         if (uart_tx !== 1'b1 || done !== 1'b0 || busy !== 1'b0) bad++;
         @(negedge clk);
      end
      chk("ab_idle", bad, 0);
      chk("ab_no_done", done_cnt, dc0);
      chk("ab_rxn", rx_n, 6);
      chk("ab_q", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/key_report_uart_tx.md
Name: key_report_uart_tx

Overview:
- Downstream consumer of the ECC scalar-multiply core.
- Accepts one (private key, public X) result pair per handshake and formats it as a 130-character ASCII line.
- Line format: 64 uppercase hex chars of priv_key, separator, 64 uppercase hex chars of pub_x, end-of-line.
- Serialises the line as 8N1 UART with no inter-character gap, then pulses done so the controller can advance the key counter.

Parameters:
- BAUD_DIV, 104, clock cycles per UART bit (12 MHz / 115200); legal values ≥ 2.
- SEP_CHAR, 8'h3A, separator byte at character index 64.
- EOL_CHAR, 8'h0A, terminator byte at character index 129.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous assert, active-high.
- in_valid  in  1  priv_key/pub_x valid.
- in_ready  out  1  block idle, can capture.
- priv_key  in  256  private scalar.
- pub_x  in  256  public key X coordinate.
- abort  in  1  synchronous request to stop the line early.
- busy  out  1  line in progress.
- done  out  1  one-cycle pulse after a full line is sent.
- char_idx  out  8  index of the character currently on the wire (0..129).
- uart_tx  out  1  serial line, idle high.

Behaviour:
- Reset (async, any time, including mid-frame): uart_tx=1, in_ready=1, busy=0, done=0, char_idx=0, state=IDLE. A partial character is simply abandoned.
- Capture: on an edge with in_valid && in_ready, both 256-bit words are registered. Next cycle: busy=1, in_ready=0, uart_tx=0 (start bit of char 0). in_valid while busy is ignored; captured data does not change.
- Character map (from the captured copy):
  - idx 0..63 = hex of priv_key[255-4i -: 4]
  - idx 64 = SEP_CHAR
  - idx 65..128 = hex of pub_x[255-4(i-65) -: 4]
  - idx 129 = EOL_CHAR
  - Nibble 0-9 maps to 8'h30+n; A-F maps to 8'h41+(n-10).
- FSM: IDLE -> START -> DATA -> STOP.
  - START: uart_tx=0 for BAUD_DIV cycles.
  - DATA: 8 bits, LSB first, BAUD_DIV cycles each; 3-bit bit counter.
  - STOP: uart_tx=1 for BAUD_DIV cycles.
  - After STOP: if char_idx<129, increment char_idx and go to START on the following cycle (zero idle gap). Else go to IDLE.
- Baud counter counts 0..BAUD_DIV-1 and wraps.
- Line length: exactly 1300*BAUD_DIV cycles from the first start-bit cycle to the end of the last stop bit.
- Completion: in the cycle after the last stop bit, done=1 for exactly one cycle, busy=0, in_ready=1, char_idx=0.
  - in_valid high in that same cycle is captured, and a new start bit follows next cycle (back-to-back lines).
- abort: sampled while busy.
  - Sets a sticky flag. The current character finishes through its stop bit, then the block returns to IDLE with no done pulse.
  - abort in IDLE has no effect. abort and capture in the same cycle: capture wins and the flag stays clear.
- uart_tx is a registered output, so no glitches.

Test Plan:
1. BAUD_DIV=4. Capture priv_key=2^71 and pub_x = 256'h0123456789ABCDEF repeated 4 times. Decoded line must be 46×'0', '8', 17×'0', ':', "0123456789ABCDEF"×4, 0x0A. done pulses exactly 5200 cycles after the first start-bit cycle.
2. BAUD_DIV=4, first char '0' (0x30). Wire must read 0, then 0,0,0,0,1,1,0,0, then 1, each level held 4 cycles. Next start bit follows immediately; uart_tx never idles between characters.
3. During a line, drive in_valid with different data (priv_key=all-ones). Remaining characters come from the original capture. in_ready stays 0 until done.
4. Assert rst at char_idx=10, mid data bit. uart_tx=1 and busy=0 take effect without waiting for a clock edge. After release, in_ready=1 and a new capture restarts at char_idx=0.
5. Hold in_valid high continuously. Capture must occur in the done cycle, and the next start bit must begin the following cycle. Two done pulses must be exactly 1300*BAUD_DIV+1 cycles apart.
6. Pulse abort during char 5's data bits. Char 5 completes including its stop bit, uart_tx then stays 1, no done pulse occurs, and in_ready=1 afterwards.
